// File: rtl/mii_net_rx_fcs_check_if.sv
// Byte-stream bundle for the MII receive FCS checker.
//   i_frame, i_d, i_d_valid, i_err        : receive byte stream (driven by the MAC byte assembler)
//   o_d, o_d_valid, o_sof                 : payload bytes with FCS stripped
//   o_eof, o_frame_good, o_frame_bad,
//   o_crc_err, o_len_err, o_len           : end-of-frame status, valid while o_eof is high
// master = byte-stream source / status sink, slave = the checker.
interface mii_net_rx_fcs_check_if;
    logic        i_frame;
    logic [7:0]  i_d;
    logic        i_d_valid;
    logic        i_err;

    logic [7:0]  o_d;
    logic        o_d_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_frame_good;
    logic        o_frame_bad;
    logic        o_crc_err;
    logic        o_len_err;
    logic [10:0] o_len;

    modport master (
        output i_frame, i_d, i_d_valid, i_err,
        input  o_d, o_d_valid, o_sof, o_eof,
        input  o_frame_good, o_frame_bad, o_crc_err, o_len_err, o_len
    );

    modport slave (
        input  i_frame, i_d, i_d_valid, i_err,
        output o_d, o_d_valid, o_sof, o_eof,
        output o_frame_good, o_frame_bad, o_crc_err, o_len_err, o_len
    );
endinterface

// File: rtl/mii_net_rx_fcs_check.sv
// Receive-side frame checker for the MII byte path.
// Strips preamble/SFD, forwards payload with the trailing 4-byte FCS removed,
// checks the CRC32 residue and the frame length, and strobes status at end of frame.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset
//   bus     : byte stream in, payload + status out (see mii_net_rx_fcs_check_if)
// Parameters:
//   MIN_LEN / MAX_LEN : legal frame length in bytes, SFD excluded, FCS included.
module mii_net_rx_fcs_check #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mii_net_rx_fcs_check_if.slave bus
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned LEN_W   = 11;
    localparam int unsigned DLY_N   = 4;
    localparam int unsigned FILL_W  = 3;
    localparam int unsigned LEN_SAT = (1 << LEN_W) - 1;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [7:0]  BYTE_PRE    = 8'h55;
    localparam logic [7:0]  BYTE_SFD    = 8'hD5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;

    logic [31:0]                 crc_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        err_q;
    logic [DLY_N-1:0][7:0]       dly_q;
    logic [FILL_W-1:0]           fill_q;
    logic                        sof_pend_q;

    logic [7:0]                  od_q;
    logic                        od_valid_q;
    logic                        sof_q;
    logic                        eof_q;
    logic                        good_q;
    logic                        bad_q;
    logic                        crc_err_q;
    logic                        len_err_q;
    logic [LEN_W-1:0]            len_q;

    logic                        accept_c;
    logic                        start_c;
    logic                        data_acc_c;
    logic                        end_c;
    logic                        crc_ok_c;
    logic                        len_ok_c;
    logic [CNT_W-1:0]            pay_c;
    logic [LEN_W-1:0]            len_c;

    // One byte of reflected CRC32, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign accept_c   = bus.i_d_valid && bus.i_frame;
    assign start_c    = accept_c && (bus.i_d == BYTE_SFD)
                        && ((state_q == ST_IDLE) || (state_q == ST_PREAMBLE));
    assign data_acc_c = (state_q == ST_DATA) && accept_c;
    assign end_c      = (state_q == ST_DATA) && !bus.i_frame;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (bus.i_d == BYTE_PRE)      state_d = ST_PREAMBLE;
                    else if (bus.i_d == BYTE_SFD) state_d = ST_DATA;
                    else                          state_d = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!bus.i_frame) begin
                    state_d = ST_IDLE;
                end else if (accept_c && (bus.i_d != BYTE_PRE)) begin
                    state_d = (bus.i_d == BYTE_SFD) ? ST_DATA : ST_DROP;
                end
            end
            ST_DATA: begin
                if (!bus.i_frame) state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (!bus.i_frame) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // End-of-frame status terms from the accumulated frame state.
    always_comb begin
        crc_ok_c = (crc_q == CRC_RESIDUE);
        len_ok_c = (cnt_q >= CNT_W'(DLY_N))
                   && (32'(cnt_q) >= MIN_LEN)
                   && (32'(cnt_q) <= MAX_LEN);
        pay_c    = '0;
        len_c    = '0;
        if (cnt_q >= CNT_W'(DLY_N)) begin
            pay_c = cnt_q - CNT_W'(DLY_N);
            len_c = (pay_c > CNT_W'(LEN_SAT)) ? LEN_W'(LEN_SAT) : pay_c[LEN_W-1:0];
        end
    end

    // Frame datapath: CRC, byte counter, FCS delay line and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            crc_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            dly_q      <= '0;
            fill_q     <= '0;
            sof_pend_q <= 1'b0;
            od_q       <= '0;
            od_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            len_q      <= '0;
        end else begin
            od_q       <= '0;
            od_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            len_q      <= '0;

            if (start_c) begin
                crc_q      <= CRC_INIT;
                cnt_q      <= '0;
                err_q      <= 1'b0;
                dly_q      <= '0;
                fill_q     <= '0;
                sof_pend_q <= 1'b1;
            end

            if (data_acc_c) begin
                crc_q <= crc_byte(crc_q, bus.i_d);
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                if (bus.i_err) err_q <= 1'b1;
                dly_q <= {dly_q[DLY_N-2:0], bus.i_d};
                // Only a full delay line releases its oldest byte; the last four are the FCS.
                if (fill_q == FILL_W'(DLY_N)) begin
                    od_q       <= dly_q[DLY_N-1];
                    od_valid_q <= 1'b1;
                    sof_q      <= sof_pend_q;
                    sof_pend_q <= 1'b0;
                end else begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end

            if (end_c) begin
                eof_q     <= 1'b1;
                good_q    <= crc_ok_c && len_ok_c && !err_q;
                bad_q     <= !(crc_ok_c && len_ok_c && !err_q);
                crc_err_q <= !crc_ok_c;
                len_err_q <= !len_ok_c;
                len_q     <= len_c;
            end
        end
    end

    assign bus.o_d          = od_q;
    assign bus.o_d_valid    = od_valid_q;
    assign bus.o_sof        = sof_q;
    assign bus.o_eof        = eof_q;
    assign bus.o_frame_good = good_q;
    assign bus.o_frame_bad  = bad_q;
    assign bus.o_crc_err    = crc_err_q;
    assign bus.o_len_err    = len_err_q;
    assign bus.o_len        = len_q;

endmodule

// File: tb/tb_mii_net_rx_fcs_check.sv
// Bench for mii_net_rx_fcs_check: two instances share one byte stream, one with
// MIN_LEN=13 and one with default lengths, and both are checked against a
// frame-level reference model (expected payload stream, SOF positions, status per frame).
module tb_mii_net_rx_fcs_check;

    localparam int unsigned MAX_LEN = 1518;
    localparam int unsigned MIN_S   = 13;
    localparam int unsigned MIN_D   = 64;

    typedef struct packed {
        logic        good;
        logic        bad;
        logic        crc_err;
        logic        len_err;
        logic [10:0] len;
    } stat_t;

    typedef logic [7:0] bq_t[$];
    typedef int         iq_t[$];
    typedef stat_t      sq_t[$];

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       frame_r = 1'b0;
    logic       dv_r = 1'b0;
    logic       err_r = 1'b0;
    logic [7:0] d_r = 8'h00;
    bit         mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mii_net_rx_fcs_check_if ifs ();
    mii_net_rx_fcs_check_if ifd ();

    assign ifs.i_frame = frame_r;
    assign ifs.i_d = d_r;
    assign ifs.i_d_valid = dv_r;
    assign ifs.i_err = err_r;
    assign ifd.i_frame = frame_r;
    assign ifd.i_d = d_r;
    assign ifd.i_d_valid = dv_r;
    assign ifd.i_err = err_r;

    mii_net_rx_fcs_check #(.MIN_LEN(MIN_S), .MAX_LEN(MAX_LEN)) dut_s (
        .i_clk(i_clk), .i_reset(i_reset), .bus(ifs)
    );
    mii_net_rx_fcs_check #(.MIN_LEN(MIN_D), .MAX_LEN(MAX_LEN)) dut_d (
        .i_clk(i_clk), .i_reset(i_reset), .bus(ifd)
    );

    // Observed streams.
    bq_t got_pay_s, got_pay_d;
    iq_t got_sof_s, got_sof_d;
    sq_t got_st_s, got_st_d;

    // Expected streams.
    bq_t exp_pay;
    iq_t exp_sofpos;
    sq_t exp_st_s, exp_st_d;
    bit  exp_chk_crc[$];

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (ifs.o_sof) got_sof_s.push_back(ifs.o_d_valid ? got_pay_s.size() : -1);
            if (ifs.o_d_valid) got_pay_s.push_back(ifs.o_d);
            if (ifs.o_eof) got_st_s.push_back({ifs.o_frame_good, ifs.o_frame_bad,
                                               ifs.o_crc_err, ifs.o_len_err, ifs.o_len});
            if (ifd.o_sof) got_sof_d.push_back(ifd.o_d_valid ? got_pay_d.size() : -1);
            if (ifd.o_d_valid) got_pay_d.push_back(ifd.o_d);
            if (ifd.o_eof) got_st_d.push_back({ifd.o_frame_good, ifd.o_frame_bad,
                                               ifd.o_crc_err, ifd.o_len_err, ifd.o_len});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard CRC-32 of a message (MSB-first register, bit-reflected input, reflected+inverted output).
    function automatic logic [31:0] crc32_ref(input bq_t m);
        logic [31:0] r;
        logic [31:0] out;
        logic        fb;
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < m.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[31] ^ m[i][b];
                r = {r[30:0], 1'b0};
                if (fb) r = r ^ 32'h04C1_1DB7;
            end
        end
        for (int k = 0; k < 32; k++) out[k] = ~r[31-k];
        return out;
    endfunction

    function automatic stat_t model_status(input int n, input int plen, input bit crc_ok,
                                           input bit err, input int unsigned min_len);
        stat_t st;
        bit    len_ok;
        len_ok     = (n >= 4) && (n >= int'(min_len)) && (n <= int'(MAX_LEN));
        st.good    = crc_ok && len_ok && !err;
        st.bad     = !st.good;
        st.crc_err = !crc_ok;
        st.len_err = !len_ok;
        st.len     = 11'((plen > 2047) ? 2047 : plen);
        return st;
    endfunction

    // body = every byte after the SFD, FCS included.
    task automatic expect_frame(input bq_t body, input bit crc_ok, input bit err);
        int n;
        int plen;
        n = body.size();
        plen = (n >= 4) ? n - 4 : 0;
        if (plen > 0) exp_sofpos.push_back(exp_pay.size());
        for (int i = 0; i < plen; i++) exp_pay.push_back(body[i]);
        exp_chk_crc.push_back(n >= 4);
        exp_st_s.push_back(model_status(n, plen, crc_ok, err, MIN_S));
        exp_st_d.push_back(model_status(n, plen, crc_ok, err, MIN_D));
    endtask

    function automatic bq_t mk_wire(input int npre, input bq_t body);
        bq_t w;
        for (int i = 0; i < npre; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (body[i]) w.push_back(body[i]);
        return w;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        frame_r = 1'b0;
        dv_r = 1'b0;
        err_r = 1'b0;
        repeat (n) tick();
    endtask

    // Drives one frame with random valid gaps; ends after the cycle in which i_frame is low.
    task automatic send(input bq_t w, input int gmin, input int gmax, input int eidx);
        for (int i = 0; i < w.size(); i++) begin
            repeat (int'($urandom_range(gmax, gmin))) begin
                frame_r = 1'b1;
                dv_r = 1'b0;
                d_r = 8'($urandom);
                err_r = 1'($urandom);
                tick();
            end
            frame_r = 1'b1;
            dv_r = 1'b1;
            d_r = w[i];
            err_r = (i == eidx);
            tick();
        end
        frame_r = 1'b0;
        dv_r = 1'($urandom);
        d_r = 8'($urandom);
        err_r = 1'($urandom);
        tick();
        dv_r = 1'b0;
        err_r = 1'b0;
    endtask

    task automatic check_dut(input string tag, input bq_t gp, input iq_t gs,
                             input sq_t gst, input sq_t est);
        int mis;
        int nf;
        mis = 0;
        check_eq({tag, "_pay_count"}, gp.size(), exp_pay.size());
        for (int i = 0; i < gp.size() && i < exp_pay.size(); i++)
            if (gp[i] !== exp_pay[i]) mis++;
        check_eq({tag, "_pay_bad_bytes"}, mis, 0);
        mis = (gs.size() != exp_sofpos.size()) ? 1 : 0;
        for (int i = 0; i < gs.size() && i < exp_sofpos.size(); i++)
            if (gs[i] != exp_sofpos[i]) mis++;
        check_eq({tag, "_sof_bad"}, mis, 0);
        check_eq({tag, "_eof_count"}, gst.size(), est.size());
        nf = (gst.size() < est.size()) ? gst.size() : est.size();
        for (int i = 0; i < nf; i++) begin
            check_eq($sformatf("%s_status%0d", tag, i),
                     {gst[i].good, gst[i].bad, gst[i].len_err, gst[i].len},
                     {est[i].good, est[i].bad, est[i].len_err, est[i].len});
            if (exp_chk_crc[i])
                check_eq($sformatf("%s_crc_err%0d", tag, i), gst[i].crc_err, est[i].crc_err);
        end
    endtask

    task automatic check_all(input string grp);
        check_dut({grp, "_min13"}, got_pay_s, got_sof_s, got_st_s, exp_st_s);
        check_dut({grp, "_min64"}, got_pay_d, got_sof_d, got_st_d, exp_st_d);
        got_pay_s.delete(); got_sof_s.delete(); got_st_s.delete();
        got_pay_d.delete(); got_sof_d.delete(); got_st_d.delete();
        exp_pay.delete(); exp_sofpos.delete(); exp_st_s.delete(); exp_st_d.delete();
        exp_chk_crc.delete();
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_min13"}, 32'({ifs.o_d, ifs.o_d_valid, ifs.o_sof, ifs.o_eof,
                  ifs.o_frame_good, ifs.o_frame_bad, ifs.o_crc_err, ifs.o_len_err, ifs.o_len}), 0);
        check_eq({tag, "_min64"}, 32'({ifd.o_d, ifd.o_d_valid, ifd.o_sof, ifd.o_eof,
                  ifd.o_frame_good, ifd.o_frame_bad, ifd.o_crc_err, ifd.o_len_err, ifd.o_len}), 0);
    endtask

    task automatic rand_frame(input int plen, input bit mess);
        bq_t         body;
        logic [31:0] fcs;
        bit          corrupt;
        bit          err;
        int          npre;
        int          eidx;
        int          pos;
        for (int i = 0; i < plen; i++) body.push_back(8'($urandom));
        fcs = crc32_ref(body);
        for (int k = 0; k < 4; k++) body.push_back(fcs[8*k +: 8]);
        corrupt = mess && ($urandom_range(3, 0) == 0);
        err = mess && ($urandom_range(5, 0) == 0);
        if (corrupt) begin
            pos = int'($urandom_range(body.size() - 1, 0));
            body[pos] = body[pos] ^ 8'($urandom_range(255, 1));
        end
        npre = int'($urandom_range(7, 0));
        eidx = err ? npre + 1 + int'($urandom_range(body.size() - 1, 0)) : -1;
        send(mk_wire(npre, body), 0, mess ? 2 : 0, eidx);
        expect_frame(body, !corrupt, err);
    endtask

    initial begin
        bq_t f1;
        bq_t f1_bad;
        bq_t w;
        int  bnd[8];
        f1     = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};
        f1_bad = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCA};
        bnd    = '{0, 8, 9, 59, 60, 1514, 1515, 2056};

        // Reset state.
        i_reset = 1'b1;
        repeat (3) tick();
        check_outs_zero("reset_outs");
        i_reset = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Known-answer frame, good FCS (length-good only for MIN_LEN=13).
        send(mk_wire(7, f1), 0, 0, -1);
        expect_frame(f1, 1'b1, 1'b0);
        idle(10);
        check_all("good_short");

        // Corrupted last FCS byte.
        send(mk_wire(7, f1_bad), 0, 0, -1);
        expect_frame(f1_bad, 1'b0, 1'b0);
        idle(10);
        check_all("bad_fcs");

        // SFD followed by only three bytes.
        w = '{8'h01, 8'h02, 8'h03};
        send(mk_wire(7, w), 0, 0, -1);
        expect_frame(w, 1'b0, 1'b0);
        idle(10);
        check_all("runt");

        // Bad preamble dropped, then two frames back-to-back re-rising in the o_eof cycle.
        w = '{8'h55, 8'h12, 8'h55, 8'hD5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        send(w, 0, 0, -1);
        send(mk_wire(7, f1), 0, 0, -1);
        expect_frame(f1, 1'b1, 1'b0);
        send(mk_wire(7, f1), 0, 0, -1);
        expect_frame(f1, 1'b1, 1'b0);
        idle(10);
        check_all("drop_b2b");

        // PHY error on byte 0x35 with 2-cycle valid gaps.
        send(mk_wire(7, f1), 2, 2, 12);
        expect_frame(f1, 1'b1, 1'b1);
        idle(10);
        check_all("phy_err_gaps");

        // Reset after byte 0x33 with i_frame still high.
        w = mk_wire(7, f1);
        for (int i = 0; i <= 10; i++) begin
            frame_r = 1'b1;
            dv_r = 1'b1;
            d_r = w[i];
            err_r = 1'b0;
            tick();
        end
        i_reset = 1'b1;
        d_r = w[11];
        tick();
        i_reset = 1'b0;
        dv_r = 1'b0;
        check_outs_zero("reset_mid");
        for (int i = 12; i < w.size(); i++) begin
            dv_r = 1'b1;
            d_r = w[i];
            tick();
        end
        idle(3);
        send(w, 0, 0, -1);
        expect_frame(f1, 1'b1, 1'b0);
        idle(10);
        check_all("reset_mid_frame");

        // Length boundaries, clean frames.
        foreach (bnd[i]) begin
            rand_frame(bnd[i], 1'b0);
            idle(int'($urandom_range(3, 1)));
        end
        idle(10);
        check_all("len_bounds");

        // Random frames: gaps, PHY errors, corrupted bytes, back-to-back or idle spacing.
        for (int f = 0; f < 40; f++) begin
            rand_frame(int'($urandom_range(90, 0)), 1'b1);
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(4, 1)));
        end
        idle(10);
        check_all("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mii_net_rx_fcs_check.md
# mii_net_rx_fcs_check

- Receive-side frame checker for the MII byte path; counterpart to the transmit CRC32/FCS generator.
- Consumes the assembled receive byte stream, strips preamble/SFD and the trailing 4-byte FCS, and forwards payload bytes downstream.
- Checks the 802.3 CRC32 residue and the frame length, and reports a one-cycle good/bad status strobe at end of frame.

## Interface

**Parameters**
- MIN_LEN, 64: minimum frame length in bytes, SFD excluded, FCS included.
- MAX_LEN, 1518: maximum frame length in bytes, same counting.

**Ports**
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_frame  in  1  frame active (byte-domain RX_DV).
- i_d  in  8  receive byte.
- i_d_valid  in  1  byte strobe; a byte is accepted only when i_d_valid && i_frame.
- i_err  in  1  PHY error; sampled on accepted bytes only.
- o_d  out  8  payload byte (FCS stripped).
- o_d_valid  out  1  o_d valid, one-cycle pulse per byte.
- o_sof  out  1  high with the first payload byte of a frame.
- o_eof  out  1  one-cycle status strobe at end of frame; o_frame_good, o_frame_bad, o_crc_err, o_len_err and o_len are valid only in this cycle.
- o_frame_good  out  1  frame passed all checks.
- o_frame_bad  out  1  frame failed at least one check.
- o_crc_err  out  1  residue mismatch.
- o_len_err  out  1  length outside [MIN_LEN, MAX_LEN], or fewer than 4 bytes after SFD.
- o_len  out  11  payload bytes delivered (FCS excluded); saturates at 2047.

## Operation

**State machine: IDLE, PREAMBLE, DATA, DROP.**
- **IDLE**
  - Accepted 0x55 -> PREAMBLE.
  - Accepted 0xD5 -> DATA. CRC is initialised to 0xFFFFFFFF; counters, error flag and delay line are cleared.
  - Any other accepted byte -> DROP.
- **PREAMBLE**
  - 0x55 -> stay.
  - 0xD5 -> DATA, with the same initialisation as from IDLE.
  - Any other byte -> DROP.
  - i_frame low -> IDLE. No o_eof is produced.
- **DROP**
  - Stay until i_frame is low, then -> IDLE. No o_eof, no data output.
- **DATA**
  - Each accepted byte updates the CRC: reflected, LSB first, polynomial 0xEDB88320.
  - The 12-bit saturating frame-byte counter increments.
  - The byte is pushed into a 4-entry delay line.
  - i_err on an accepted byte sets a sticky error flag.
  - On the first DATA cycle with i_frame low -> IDLE, and the status is registered on the same edge.

**FCS stripping**
- A byte leaves the delay line only when a newer byte pushes it out, i.e. the delay line already holds 4 bytes.
- The 4 bytes still held at end of frame are the FCS and are discarded.

**Status computation**
- crc_ok = (CRC register == 0xDEBB20E3), the good residue without final XOR.
- len_ok = count ≥ 4, count ≥ MIN_LEN and count ≤ MAX_LEN.
- o_crc_err = !crc_ok.
- o_len_err = !len_ok.
- o_frame_good = crc_ok && len_ok && !err.
- o_frame_bad = !o_frame_good.
- o_len = min(count−4, 2047); 0 if count < 4.

**Reset** (any time, including mid-frame)
- State -> IDLE.
- All outputs 0: o_d = 0x00, o_len = 0, and every strobe/flag 0.
- If i_frame is still high after reset, the remaining bytes are not 0x55/0xD5 in general, so the frame falls into DROP. No partial frame output, no o_eof.

## Timing

- Payload byte n is presented on o_d/o_d_valid in the cycle after byte n+4 is accepted; all outputs are registered.
- o_sof coincides with the o_d_valid of payload byte 0.
- o_eof asserts in the first IDLE cycle after the DATA cycle that sees i_frame low.
- If i_frame falls in the same cycle as i_d_valid, that byte is not accepted.
- Back-to-back frames: i_frame may re-rise in the o_eof cycle. Bytes accepted in that cycle are processed by IDLE normally.
- Non-status outputs are held at 0 when not strobed. o_d is don't-care when o_d_valid is low.
- Throughput: one byte per cycle sustained; i_d_valid gaps are permitted anywhere.

## Test plan

1. **Good short frame** (MIN_LEN=13)
   - Stimulus: 7×0x55, 0xD5, "123456789" (0x31..0x39), FCS 0x26 0x39 0xF4 0xCB.
   - Required: 9 o_d_valid pulses 0x31..0x39, o_sof on 0x31; o_eof with o_frame_good=1, o_crc_err=0, o_len_err=0, o_len=9.
2. **Corrupt FCS**
   - Stimulus: same frame with the last FCS byte 0xCA.
   - Required: payload still delivered; o_eof with o_crc_err=1, o_frame_bad=1, o_len=9.
3. **Length violations** (default parameters)
   - Stimulus: the frame of test 1.
   - Required: o_len_err=1, o_frame_bad=1, o_crc_err=0.
   - Stimulus: SFD followed by only 3 bytes.
   - Required: no o_d_valid; o_len_err=1, o_len=0.
4. **Bad preamble, then a good frame**
   - Stimulus: 0x55, 0x12, … until i_frame low; then frame 1 back-to-back, with i_frame re-rising in the o_eof cycle.
   - Required: no output and no o_eof for the first frame; frame 1 reported good.
5. **i_err mid-frame plus i_d_valid gaps**
   - Stimulus: frame 1 with i_err on byte 0x35 and 2-cycle i_d_valid gaps.
   - Required: payload bytes unchanged; o_frame_bad=1, o_crc_err=0.
6. **Reset mid-frame**
   - Stimulus: assert i_reset after byte 0x33 of frame 1 while i_frame stays high.
   - Required: all outputs 0 on the next cycle; no o_eof for that frame; the following clean frame is reported good.
